hera_wb_sched: RTL and testbench
================================

Name: hera_wb_sched

Overview:
- Write-back scheduler for the HERA register file, which has a single write port shared by ALU/exec results, returning memory loads and an optional debug host.
- Buffers outstanding loads in order and keeps a 16-bit pending-register scoreboard.
- Raises a source hazard for decode when an operand waits on a load, and drives one registered write per cycle into the register file.

Parameters:
- LDQ_DEPTH, 4, load queue entries; power of two, 2..8.
- DBG_STARVE, 8, cycles a debug request may wait before it outranks load retire.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ex_wr_en  in  1  exec result valid this cycle
- ex_rd  in  4  exec destination
- ex_data  in  16  exec result
- ld_req  in  1  load issued; push ld_rd into queue
- ld_rd  in  4  load destination
- ld_rsp_valid  in  1  memory data return; returns arrive in issue order
- ld_rsp_data  in  16  returned data
- rsa  in  4  decode source A
- rsb  in  4  decode source B
- src_hazard  out  1  rsa or rsb pending
- ldq_full  out  1  queue holds LDQ_DEPTH entries
- pending  out  16  scoreboard, bit n = register n awaits load
- err  out  1  sticky protocol error
- dbg_req  in  1  debug write request
- dbg_addr  in  4  debug address
- dbg_data  in  16  debug data
- dbg_gnt  out  1  one-cycle grant
- wr_en  out  1  register file write strobe
- wr_addr  out  4  register file write address
- wr_data  out  16  register file write data
- wr_src  out  2  00 exec, 01 load, 10 debug

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, wr_src=0.
  - dbg_gnt=0, err=0.
  - Queue empty, so pending=0, ldq_full=0, src_hazard=0.
  - Starvation counter=0.
- Queue entries hold {valid, rd, data, dvalid, kill}. head/tail/count are registers.
- Push:
  - ld_req with count<LDQ_DEPTH writes {1, ld_rd, x, 0, 0} at tail.
  - ld_req with count==LDQ_DEPTH is dropped and sets err.
  - Fullness uses registered count; a same-cycle retire does not free a slot.
- Fill:
  - ld_rsp_valid writes data into the oldest entry with dvalid=0 and sets its dvalid.
  - A response with no such entry is dropped and sets err.
- Retire candidate: the head entry with dvalid=1. An entry filled this cycle is eligible next cycle at the earliest.
- Write arbitration, one winner per cycle:
  - Priority is exec > load retire > debug.
  - Exception: when the starvation counter is >= DBG_STARVE, debug outranks load retire.
  - Exec is never blocked.
- Outputs are registered: wr_* reflect the winner one cycle later.
- wr_en is forced to 0 when the winning address is 0 (R0 is hardwired). A load to r0 still occupies an entry and consumes a response.
- Load retire:
  - Pops the head entry.
  - If kill=1 the entry pops without a write (wr_en=0, port free). The port then goes to debug if requesting, otherwise it idles.
- WAW handling: an exec write to rd sets kill on every valid queue entry with rd==ex_rd, because the exec result is younger.
- Scoreboard: pending[n] = OR over valid, non-killed entries with rd==n, n!=0. It is combinational from the queue registers.
- A push in cycle t shows in pending at t+1.
- src_hazard = (rsa!=0 & pending[rsa]) | (rsb!=0 & pending[rsb]). It is combinational.
- Debug:
  - dbg_gnt pulses in the cycle the debug write wins. The write lands on wr_* the next cycle.
  - The starvation counter increments each cycle dbg_req=1 and no grant is given, saturating at DBG_STARVE.
  - It clears on grant or when dbg_req=0.
- Simultaneous push+fill+retire in one cycle is legal; count changes by push minus pop.
- Reset mid-operation flushes the queue. Responses arriving after reset for pre-reset loads set err.

Optional Feature:
- HERA_DBG_WR_EN defined: the debug port and starvation counter are as above.
- Undefined: dbg_gnt tied 0, dbg_* inputs ignored, no counter; arbitration is exec > load only.

Test Plan:
- Reset with queue holding 3 loads -> pending=0, ldq_full=0, wr_en=0 the cycle after rst falls. A later stray ld_rsp_valid -> err=1.
- ld_req rd=5 at t0, ld_rsp 0xBEEF at t2, no exec -> wr_en=1, wr_addr=5, wr_data=0xBEEF, wr_src=01 at t4. pending[5] is 1 during t1..t3 and clears at t4.
- Load rd=7 queued, exec writes rd=7 0x1234 before the response -> 0x1234 written, load data later discarded with no write, pending[7]=0 right after the exec cycle.
- 4 loads pushed (LDQ_DEPTH=4) -> ldq_full=1. A 5th ld_req -> dropped, err=1, count stays 4.
- Exec writes every cycle while a load is filled -> load retires in the first cycle ex_wr_en=0. rsa=3 with pending[3] -> src_hazard=1. rsa=0 -> src_hazard=0.
- HERA_DBG_WR_EN: dbg_req held, loads continuously retirable -> dbg_gnt after exactly DBG_STARVE=8 waiting cycles, then counter resets.

Source files
------------

// File: rtl/hera_wb_sched.sv
`timescale 1ns/1ps
// hera_wb_sched: write-back scheduler for the single HERA register-file
// write port. Sources are exec results, in-order load returns and, when
// built with HERA_DBG_WR_EN, a debug host. Loads wait in an in-order
// queue and a 16-bit pending scoreboard drives the decode source hazard.
//
// Ports:
//   clk, rst (async, active-low)
//   ex_wr_en/ex_rd/ex_data          exec result
//   ld_req/ld_rd                    load issue (queue push)
//   ld_rsp_valid/ld_rsp_data        in-order memory return (queue fill)
//   rsa/rsb -> src_hazard           decode operand check (combinational)
//   ldq_full, pending               queue state (combinational)
//   err                             sticky protocol error
//   dbg_req/dbg_addr/dbg_data/dbg_gnt  debug write (grant combinational)
//   wr_en/wr_addr/wr_data/wr_src    registered register-file write
//
// Build option: define HERA_DBG_WR_EN to enable the debug port and its
// starvation counter; otherwise dbg_gnt is 0 and dbg_* are ignored.
module hera_wb_sched #(
    parameter int unsigned LDQ_DEPTH  = 4,
    parameter int unsigned DBG_STARVE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wr_en,
    input  logic [3:0]  ex_rd,
    input  logic [15:0] ex_data,
    input  logic        ld_req,
    input  logic [3:0]  ld_rd,
    input  logic        ld_rsp_valid,
    input  logic [15:0] ld_rsp_data,
    input  logic [3:0]  rsa,
    input  logic [3:0]  rsb,
    output logic        src_hazard,
    output logic        ldq_full,
    output logic [15:0] pending,
    output logic        err,
    input  logic        dbg_req,
    input  logic [3:0]  dbg_addr,
    input  logic [15:0] dbg_data,
    output logic        dbg_gnt,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [1:0]  wr_src
);

    localparam int unsigned AW = (LDQ_DEPTH > 2) ? $clog2(LDQ_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [1:0]  SRC_EX  = 2'b00;
    localparam logic [1:0]  SRC_LD  = 2'b01;
    localparam logic [1:0]  SRC_DBG = 2'b10;

    logic [LDQ_DEPTH-1:0] q_valid;
    logic [LDQ_DEPTH-1:0] q_dvalid;
    logic [LDQ_DEPTH-1:0] q_kill;
    logic [3:0]           q_rd   [LDQ_DEPTH];
    logic [15:0]          q_data [LDQ_DEPTH];
    logic [AW-1:0]        head;
    logic [AW-1:0]        tail;
    logic [CW-1:0]        count;

    logic                 push;
    logic                 pop;
    logic                 head_rdy;
    logic                 fill_hit;
    logic [AW-1:0]        fill_idx;
    logic                 dbg_req_i;
    logic                 starve_hit;
    logic                 dbg_win;
    logic                 win_en;
    logic [3:0]           win_addr;
    logic [15:0]          win_data;
    logic [1:0]           win_src;

    // Debug request qualification and starvation counter
`ifdef HERA_DBG_WR_EN
    localparam int unsigned SW = $clog2(DBG_STARVE + 1);
    logic [SW-1:0] starve;

    assign dbg_req_i  = dbg_req;
    assign starve_hit = (starve >= SW'(DBG_STARVE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (!dbg_req || dbg_win) begin
            starve <= '0;
        end else if (!starve_hit) begin
            starve <= starve + SW'(1);
        end
    end
`else
    logic unused_dbg;

    assign dbg_req_i  = 1'b0;
    assign starve_hit = 1'b0;
    assign unused_dbg = ^{dbg_req, (DBG_STARVE != 0)};
`endif

    assign ldq_full = (count == CW'(LDQ_DEPTH));
    assign push     = ld_req && !ldq_full;
    assign head_rdy = q_valid[head] && q_dvalid[head];
    assign dbg_gnt  = dbg_win;

    // Scoreboard: live (non-killed) queued loads, r0 excluded
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
            if (q_valid[AW'(i)] && !q_kill[AW'(i)] && (q_rd[AW'(i)] != 4'd0)) begin
                pending[q_rd[AW'(i)]] = 1'b1;
            end
        end
    end

    assign src_hazard = ((rsa != 4'd0) && pending[rsa]) || ((rsb != 4'd0) && pending[rsb]);

    // Oldest occupied entry still waiting for its data
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = head;
        for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
            if (!fill_hit && (CW'(i) < count) && !q_dvalid[head + AW'(i)]) begin
                fill_hit = 1'b1;
                fill_idx = head + AW'(i);
            end
        end
    end

    // Write-port arbitration; a killed head pops without using the port
    always_comb begin
        win_en   = 1'b0;
        win_addr = '0;
        win_data = '0;
        win_src  = SRC_EX;
        pop      = 1'b0;
        dbg_win  = 1'b0;
        if (ex_wr_en) begin
            win_en   = 1'b1;
            win_addr = ex_rd;
            win_data = ex_data;
            win_src  = SRC_EX;
        end else begin
            if (head_rdy && !(dbg_req_i && starve_hit)) begin
                pop = 1'b1;
                if (!q_kill[head]) begin
                    win_en   = 1'b1;
                    win_addr = q_rd[head];
                    win_data = q_data[head];
                    win_src  = SRC_LD;
                end
            end
            if (!win_en && dbg_req_i) begin
                dbg_win  = 1'b1;
                win_en   = 1'b1;
                win_addr = dbg_addr;
                win_data = dbg_data;
                win_src  = SRC_DBG;
            end
        end
    end

    // Load queue, error flag and registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid  <= '0;
            q_dvalid <= '0;
            q_kill   <= '0;
            for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
                q_rd[AW'(i)]   <= '0;
                q_data[AW'(i)] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_src  <= SRC_EX;
        end else begin
            // A younger exec write supersedes queued loads to the same rd
            if (ex_wr_en) begin
                for (int unsigned i = 0; i < LDQ_DEPTH; i++) begin
                    if (q_valid[AW'(i)] && (q_rd[AW'(i)] == ex_rd)) begin
                        q_kill[AW'(i)] <= 1'b1;
                    end
                end
            end
            if (ld_rsp_valid) begin
                if (fill_hit) begin
                    q_data[fill_idx]   <= ld_rsp_data;
                    q_dvalid[fill_idx] <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= head + AW'(1);
            end
            if (push) begin
                q_valid[tail]  <= 1'b1;
                q_rd[tail]     <= ld_rd;
                q_dvalid[tail] <= 1'b0;
                q_kill[tail]   <= 1'b0;
                tail           <= tail + AW'(1);
            end
            if (ld_req && ldq_full) begin
                err <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);

            wr_en <= win_en && (win_addr != 4'd0);
            if (win_en) begin
                wr_addr <= win_addr;
                wr_data <= win_data;
                wr_src  <= win_src;
            end
        end
    end

endmodule

// File: tb/tb_hera_wb_sched.sv
`timescale 1ns/1ps
// Bench for hera_wb_sched: directed scenarios plus random traffic against
// a queue-based reference model; expected writes go to a scoreboard that a
// separate monitor drains when wr_en is observed.
module tb_hera_wb_sched;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STARVE = 8;
`ifdef HERA_DBG_WR_EN
    localparam bit DBG_ON = 1'b1;
`else
    localparam bit DBG_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_wr_en, ld_req, ld_rsp_valid, dbg_req;
    logic [3:0]  ex_rd, ld_rd, rsa, rsb, dbg_addr;
    logic [15:0] ex_data, ld_rsp_data, dbg_data;
    logic        src_hazard, ldq_full, err, dbg_gnt, wr_en;
    logic [15:0] pending, wr_data;
    logic [3:0]  wr_addr;
    logic [1:0]  wr_src;

    hera_wb_sched #(.LDQ_DEPTH(DEPTH), .DBG_STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_data(ex_data),
        .ld_req(ld_req), .ld_rd(ld_rd),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
        .rsa(rsa), .rsb(rsb), .src_hazard(src_hazard), .ldq_full(ldq_full),
        .pending(pending), .err(err),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct { logic [3:0] rd; logic [15:0] data; bit filled; bit killed; } ld_t;
    typedef struct { int due; logic [3:0] addr; logic [15:0] data; logic [1:0] src; } wr_t;

    ld_t         lq[$];
    wr_t         exp_q[$];
    int          m_starve = 0;
    bit          m_err    = 1'b0;
    logic [15:0] e_pend;
    bit          e_full, e_haz, e_gnt, e_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit has_unfilled();
        foreach (lq[i]) if (!lq[i].filled) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: one clock of the scheduler, from the current inputs
    task automatic model_eval();
        bit  pop, has_w, dbg_live, done;
        int  sz;
        wr_t w;
        ld_t n;
        e_pend = '0;
        foreach (lq[i]) if (!lq[i].killed && lq[i].rd != 4'd0) e_pend[lq[i].rd] = 1'b1;
        e_full   = (lq.size() == DEPTH);
        e_haz    = (rsa != 4'd0 && e_pend[rsa]) || (rsb != 4'd0 && e_pend[rsb]);
        e_err    = m_err;
        dbg_live = DBG_ON && dbg_req;
        pop = 1'b0; has_w = 1'b0; e_gnt = 1'b0;
        w = '{due: cyc + 1, addr: 4'd0, data: 16'd0, src: 2'd0};
        if (ex_wr_en) begin
            has_w = 1'b1; w.addr = ex_rd; w.data = ex_data; w.src = 2'b00;
        end else begin
            if (lq.size() > 0 && lq[0].filled && !(dbg_live && m_starve >= STARVE)) begin
                pop = 1'b1;
                if (!lq[0].killed) begin
                    has_w = 1'b1; w.addr = lq[0].rd; w.data = lq[0].data; w.src = 2'b01;
                end
            end
            if (!has_w && dbg_live) begin
                has_w = 1'b1; e_gnt = 1'b1; w.addr = dbg_addr; w.data = dbg_data; w.src = 2'b10;
            end
        end
        if (has_w && w.addr != 4'd0) exp_q.push_back(w);
        if (ex_wr_en) foreach (lq[i]) if (lq[i].rd == ex_rd) lq[i].killed = 1'b1;
        if (ld_rsp_valid) begin
            done = 1'b0;
            foreach (lq[i]) if (!done && !lq[i].filled) begin
                lq[i].data = ld_rsp_data; lq[i].filled = 1'b1; done = 1'b1;
            end
            if (!done) m_err = 1'b1;
        end
        sz = lq.size();
        if (pop) void'(lq.pop_front());
        if (ld_req) begin
            if (sz < DEPTH) begin
                n = '{rd: ld_rd, data: 16'd0, filled: 1'b0, killed: 1'b0};
                lq.push_back(n);
            end else begin
                m_err = 1'b1;
            end
        end
        if (!dbg_live || e_gnt) m_starve = 0;
        else if (m_starve < STARVE) m_starve++;
    endtask

    task automatic idle_inputs();
        ex_wr_en = 1'b0; ex_rd = 4'd0; ex_data = 16'd0;
        ld_req = 1'b0; ld_rd = 4'd0; ld_rsp_valid = 1'b0; ld_rsp_data = 16'd0;
        rsa = 4'd0; rsb = 4'd0;
        dbg_req = 1'b0; dbg_addr = 4'd0; dbg_data = 16'd0;
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic end_cycle();
        model_eval();
        @(negedge clk);
        chk("pending", 32'(pending), 32'(e_pend));
        chk("ldq_full", 32'(ldq_full), 32'(e_full));
        chk("src_hazard", 32'(src_hazard), 32'(e_haz));
        chk("err", 32'(err), 32'(e_err));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(e_gnt));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        rsa = 4'd5;
        lq.delete(); exp_q.delete(); m_starve = 0; m_err = 1'b0;
        @(negedge clk);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ldq_full", 32'(ldq_full), 32'd0);
        chk("rst_src_hazard", 32'(src_hazard), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        begin_cycle();
        rst = 1'b1;
        end_cycle();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            begin_cycle();
            ld_rsp_valid = has_unfilled();
            ld_rsp_data  = 16'($urandom);
            end_cycle();
        end
    endtask

    // Write-port monitor: compares every cycle against the scoreboard head
    initial begin
        wr_t w;
        bit  exp_we;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
            exp_we = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("wr_en", 32'(wr_en), 32'(exp_we));
            if (exp_we && wr_en === 1'b1) begin
                w = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(w.addr));
                chk("wr_data", 32'(wr_data), 32'(w.data));
                chk("wr_src", 32'(wr_src), 32'(w.src));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        do_reset();

        // Reset with three queued loads, then a stray response
        for (int i = 0; i < 3; i++) begin
            begin_cycle(); ld_req = 1'b1; ld_rd = 4'(i + 2); end_cycle();
        end
        do_reset();
        begin_cycle(); ld_rsp_valid = 1'b1; ld_rsp_data = 16'h0bad; end_cycle();
        begin_cycle(); end_cycle();
        chk("stray_rsp_err", 32'(err), 32'd1);

        // Basic load retire: issue t0, return t2, write at t4
        do_reset();
        begin_cycle(); ld_req = 1'b1; ld_rd = 4'd5; end_cycle();
        begin_cycle(); end_cycle();
        chk("beef_pend_t1", 32'(pending[5]), 32'd1);
        begin_cycle(); ld_rsp_valid = 1'b1; ld_rsp_data = 16'hbeef; end_cycle();
        begin_cycle(); end_cycle();
        chk("beef_pend_t3", 32'(pending[5]), 32'd1);
        begin_cycle(); end_cycle();
        chk("beef_wr_en", 32'(wr_en), 32'd1);
        chk("beef_wr_addr", 32'(wr_addr), 32'd5);
        chk("beef_wr_data", 32'(wr_data), 32'hbeef);
        chk("beef_wr_src", 32'(wr_src), 32'd1);
        chk("beef_pend_t4", 32'(pending[5]), 32'd0);

        // WAW: exec to r7 kills the queued load to r7
        begin_cycle(); ld_req = 1'b1; ld_rd = 4'd7; end_cycle();
        begin_cycle(); ex_wr_en = 1'b1; ex_rd = 4'd7; ex_data = 16'h1234; end_cycle();
        begin_cycle(); end_cycle();
        chk("waw_pend7", 32'(pending[7]), 32'd0);
        chk("waw_wr_data", 32'(wr_data), 32'h1234);
        begin_cycle(); ld_rsp_valid = 1'b1; ld_rsp_data = 16'h5555; end_cycle();
        begin_cycle(); end_cycle();
        begin_cycle(); end_cycle();
        chk("waw_no_write", 32'(wr_en), 32'd0);

        // Full queue and dropped fifth load
        do_reset();
        for (int i = 0; i < 4; i++) begin
            begin_cycle(); ld_req = 1'b1; ld_rd = 4'(i + 1); end_cycle();
        end
        begin_cycle(); ld_req = 1'b1; ld_rd = 4'd9; end_cycle();
        chk("full_flag", 32'(ldq_full), 32'd1);
        begin_cycle(); end_cycle();
        chk("full_drop_err", 32'(err), 32'd1);
        chk("full_still", 32'(ldq_full), 32'd1);
        chk("full_no_r9", 32'(pending[9]), 32'd0);
        drain(10);

        // Exec blocks a ready load; hazard on r3 and r0
        do_reset();
        begin_cycle(); ld_req = 1'b1; ld_rd = 4'd3; end_cycle();
        begin_cycle(); ld_rsp_valid = 1'b1; ld_rsp_data = 16'h0333; end_cycle();
        for (int i = 0; i < 4; i++) begin
            begin_cycle();
            ex_wr_en = 1'b1; ex_rd = 4'd9; ex_data = 16'(16'h9000 + i);
            rsa = (i == 0) ? 4'd3 : 4'd0;
            end_cycle();
            chk("exec_hazard", 32'(src_hazard), (i == 0) ? 32'd1 : 32'd0);
        end
        begin_cycle(); end_cycle();
        begin_cycle(); end_cycle();
        chk("exec_then_ld_addr", 32'(wr_addr), 32'd3);
        chk("exec_then_ld_src", 32'(wr_src), 32'd1);

`ifdef HERA_DBG_WR_EN
        // Debug starvation against a continuous load-retire stream
        do_reset();
        for (int i = 0; i < 14; i++) begin
            begin_cycle();
            ld_req       = (lq.size() < DEPTH);
            ld_rd        = 4'($urandom_range(1, 15));
            ld_rsp_valid = has_unfilled();
            ld_rsp_data  = 16'($urandom);
            if (i >= 4) begin
                dbg_req  = 1'b1;
                dbg_addr = 4'($urandom_range(1, 15));
                dbg_data = 16'($urandom);
            end
            end_cycle();
            if (i >= 4) chk("dbg_starve_gnt", 32'(dbg_gnt), (i == 12) ? 32'd1 : 32'd0);
        end
        drain(10);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            begin_cycle();
            ex_wr_en    = ($urandom_range(0, 9) < 3);
            ex_rd       = 4'($urandom);
            ex_data     = 16'($urandom);
            ld_req      = ($urandom_range(0, 9) < 4);
            ld_rd       = 4'($urandom);
            ld_rsp_valid = has_unfilled() ? ($urandom_range(0, 9) < 5)
                                          : ($urandom_range(0, 199) == 0);
            ld_rsp_data = 16'($urandom);
            rsa         = 4'($urandom);
            rsb         = 4'($urandom);
            dbg_req     = ($urandom_range(0, 9) < 3);
            dbg_addr    = 4'($urandom);
            dbg_data    = 16'($urandom);
            end_cycle();
        end
        drain(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
